// File: rtl/uvmt_cv32e40s_obi_phase_counter_if.sv
// OBI bus signals observed by the phase counter.
// The monitor modport gives the counter a read-only view of the bus.
interface uvmt_cv32e40s_obi_phase_counter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic              rvalid;

  modport master  (output req, addr, input  gnt, rvalid);
  modport slave   (input  req, addr, output gnt, rvalid);
  modport monitor (input  req, gnt, addr, rvalid);
endinterface

// File: rtl/uvmt_cv32e40s_obi_phase_counter.sv
// Passive OBI monitor: counts address/response phases, tracks outstanding, flags protocol violations.
// Define OBI_PHASE_CNT_STALL_MON_EN to build the response-stall counters.
module uvmt_cv32e40s_obi_phase_counter #(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int OUTST_W         = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  uvmt_cv32e40s_obi_phase_counter_if.monitor       obi,
  output logic [31:0]                              addr_ph_cnt_o,
  output logic [31:0]                              rsp_ph_cnt_o,
  output logic [OUTST_W-1:0]                       outstanding_o,
  output logic [1:0]                               state_o,
  output logic                                     protocol_err_o,
  output logic [7:0]                               rsp_stall_cnt_o,
  output logic [7:0]                               max_rsp_stall_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_GNT = 2'd1, WAIT_RSP = 2'd2} state_e;

  localparam logic [OUTST_W-1:0] MAX_O = OUTST_W'(MAX_OUTSTANDING);

  state_e             state_q, state_d;
  logic [OUTST_W-1:0] outst_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               hs, rv, err_d;

  assign hs      = obi.req & obi.gnt;
  assign rv      = obi.rvalid;
  assign state_o = state_q;

  always_comb begin
    outst_d = outstanding_o;
    err_d   = 1'b0;
    state_d = IDLE;
    // Saturate at both ends; a simultaneous grant and response cancel out
    if (hs && !rv && outstanding_o != MAX_O)      outst_d = outstanding_o + OUTST_W'(1);
    else if (rv && !hs && outstanding_o != '0)    outst_d = outstanding_o - OUTST_W'(1);

    if (rv && outstanding_o == '0)                err_d = 1'b1;
    if (hs && !rv && outstanding_o == MAX_O)      err_d = 1'b1;
    if (state_q == WAIT_GNT && (!obi.req || obi.addr != addr_q)) err_d = 1'b1;

    // A pending ungranted request dominates any outstanding responses
    if (obi.req && !obi.gnt)   state_d = WAIT_GNT;
    else if (outst_d != '0)    state_d = WAIT_RSP;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      addr_ph_cnt_o  <= '0;
      rsp_ph_cnt_o   <= '0;
      outstanding_o  <= '0;
      protocol_err_o <= 1'b0;
      addr_q         <= '0;
    end else begin
      state_q        <= state_d;
      outstanding_o  <= outst_d;
      protocol_err_o <= protocol_err_o | err_d;
      if (hs) addr_ph_cnt_o <= addr_ph_cnt_o + 32'd1;
      if (rv) rsp_ph_cnt_o  <= rsp_ph_cnt_o + 32'd1;
      // Address is captured on entry to WAIT_GNT and must hold until the grant
      if (obi.req && !obi.gnt && state_q != WAIT_GNT) addr_q <= obi.addr;
    end
  end

`ifdef OBI_PHASE_CNT_STALL_MON_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_stall_cnt_o <= '0;
      max_rsp_stall_o <= '0;
    end else begin
      if (rv)                                                   rsp_stall_cnt_o <= '0;
      else if (outstanding_o != '0 && rsp_stall_cnt_o != 8'hFF) rsp_stall_cnt_o <= rsp_stall_cnt_o + 8'd1;
      if (rsp_stall_cnt_o > max_rsp_stall_o)                    max_rsp_stall_o <= rsp_stall_cnt_o;
    end
  end
`else
  assign rsp_stall_cnt_o = '0;
  assign max_rsp_stall_o = '0;
`endif

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_phase_counter.sv
// Directed bench for the OBI phase counter; inputs driven on negedge, outputs sampled on negedge.
module tb_uvmt_cv32e40s_obi_phase_counter;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] addr_cnt, rsp_cnt;
  logic [1:0]  outst, state;
  logic        perr;
  logic [7:0]  stall, mstall;
  int          errs = 0;
  int          checks = 0;

  always #5 clk_i = ~clk_i;

  uvmt_cv32e40s_obi_phase_counter_if #(.ADDR_W(32)) bus ();

  uvmt_cv32e40s_obi_phase_counter #(.ADDR_W(32), .MAX_OUTSTANDING(2), .OUTST_W(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .obi(bus),
    .addr_ph_cnt_o(addr_cnt), .rsp_ph_cnt_o(rsp_cnt), .outstanding_o(outst),
    .state_o(state), .protocol_err_o(perr),
    .rsp_stall_cnt_o(stall), .max_rsp_stall_o(mstall)
  );

`ifdef OBI_PHASE_CNT_STALL_MON_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  task automatic drv(input logic r, input logic g, input logic [31:0] a, input logic v);
    bus.req = r; bus.gnt = g; bus.addr = a; bus.rvalid = v;
  endtask

  task automatic step();
    @(posedge clk_i); @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; drv(0, 0, 32'h0, 0);
    step(); step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drv(1, 1, 32'h10, 0); step(); step();
    drv(1, 0, 32'h20, 1);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (addr_cnt !== 32'd0) begin errs++; $display("FAIL reset_addr_cnt: got %0h exp 0", addr_cnt); end
    checks++; if (rsp_cnt !== 32'd0)  begin errs++; $display("FAIL reset_rsp_cnt: got %0h exp 0", rsp_cnt); end
    checks++; if (outst !== 2'd0)     begin errs++; $display("FAIL reset_outst: got %0d exp 0", outst); end
    checks++; if (state !== 2'd0)     begin errs++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (perr !== 1'b0)      begin errs++; $display("FAIL reset_err: got %0b exp 0", perr); end
    checks++; if (stall !== 8'd0 || mstall !== 8'd0) begin errs++; $display("FAIL reset_stall: got %0d/%0d exp 0/0", stall, mstall); end
    drv(0, 0, 32'h0, 0);
    step(); rst_ni = 1'b1; step();
    checks++; if (perr !== 1'b0 || state !== 2'd0) begin errs++; $display("FAIL reset_release: err %0b state %0d exp 0/0", perr, state); end
  endtask

  task automatic test_basic();
    do_reset();
    drv(1, 1, 32'h40, 0); step();               // cycle 1 grant
    drv(0, 0, 32'h0, 0);
    checks++; if (addr_cnt !== 32'd1) begin errs++; $display("FAIL basic_addr_cnt: got %0d exp 1", addr_cnt); end
    checks++; if (state !== 2'd2)     begin errs++; $display("FAIL basic_state_rsp: got %0d exp 2", state); end
    for (int c = 2; c <= 4; c++) begin
      checks++; if (outst !== 2'd1) begin errs++; $display("FAIL basic_outst_c%0d: got %0d exp 1", c, outst); end
      if (c == 4) drv(0, 0, 32'h0, 1);
      step();
    end
    drv(0, 0, 32'h0, 0);
    checks++; if (rsp_cnt !== 32'd1) begin errs++; $display("FAIL basic_rsp_cnt: got %0d exp 1", rsp_cnt); end
    checks++; if (outst !== 2'd0)    begin errs++; $display("FAIL basic_outst_end: got %0d exp 0", outst); end
    checks++; if (state !== 2'd0)    begin errs++; $display("FAIL basic_state_idle: got %0d exp 0", state); end
    checks++; if (perr !== 1'b0)     begin errs++; $display("FAIL basic_err: got %0b exp 0", perr); end
  endtask

  task automatic test_wait_gnt(input bit change);
    logic [31:0] a2;
    do_reset();
    a2 = change ? 32'h104 : 32'h100;
    drv(1, 0, 32'h100, 0); step();              // cycle 0 -> now cycle 1
    checks++; if (state !== 2'd1) begin errs++; $display("FAIL wg%0d_state_c1: got %0d exp 1", change, state); end
    step();                                     // now cycle 2
    checks++; if (state !== 2'd1) begin errs++; $display("FAIL wg%0d_state_c2: got %0d exp 1", change, state); end
    drv(1, 0, a2, 0); step();                   // now cycle 3
    checks++; if (state !== 2'd1) begin errs++; $display("FAIL wg%0d_state_c3: got %0d exp 1", change, state); end
    checks++; if (perr !== change) begin errs++; $display("FAIL wg%0d_err_c3: got %0b exp %0b", change, perr, change); end
    drv(1, 1, a2, 0); step();                   // now cycle 4
    drv(0, 0, 32'h0, 0);
    checks++; if (state !== 2'd2) begin errs++; $display("FAIL wg%0d_state_c4: got %0d exp 2", change, state); end
    checks++; if (perr !== change) begin errs++; $display("FAIL wg%0d_err_c4: got %0b exp %0b", change, perr, change); end
    checks++; if (addr_cnt !== 32'd1) begin errs++; $display("FAIL wg%0d_addr_cnt: got %0d exp 1", change, addr_cnt); end
    drv(0, 0, 32'h0, 1); step(); drv(0, 0, 32'h0, 0);
    checks++; if (state !== 2'd0) begin errs++; $display("FAIL wg%0d_state_idle: got %0d exp 0", change, state); end
  endtask

  task automatic test_stray_rsp();
    do_reset();
    drv(0, 0, 32'h0, 1); step(); drv(0, 0, 32'h0, 0);
    checks++; if (perr !== 1'b1)     begin errs++; $display("FAIL stray_err: got %0b exp 1", perr); end
    checks++; if (rsp_cnt !== 32'd1) begin errs++; $display("FAIL stray_rsp_cnt: got %0d exp 1", rsp_cnt); end
    checks++; if (outst !== 2'd0)    begin errs++; $display("FAIL stray_outst: got %0d exp 0", outst); end
    step();
    checks++; if (perr !== 1'b1)     begin errs++; $display("FAIL stray_sticky: got %0b exp 1", perr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drv(1, 1, 32'h200, 0); step();
    drv(1, 1, 32'h204, 0); step();
    checks++; if (perr !== 1'b0 || outst !== 2'd2) begin errs++; $display("FAIL b2b_two: err %0b outst %0d exp 0/2", perr, outst); end
    drv(1, 1, 32'h208, 0); step(); drv(0, 0, 32'h0, 0);
    checks++; if (perr !== 1'b1)      begin errs++; $display("FAIL b2b_err: got %0b exp 1", perr); end
    checks++; if (outst !== 2'd2)     begin errs++; $display("FAIL b2b_outst: got %0d exp 2", outst); end
    checks++; if (addr_cnt !== 32'd3) begin errs++; $display("FAIL b2b_addr_cnt: got %0d exp 3", addr_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.addr_ph_cnt_o = 32'hFFFF_FFFE;
    force dut.rsp_ph_cnt_o  = 32'hFFFF_FFFE;
    step();
    release dut.addr_ph_cnt_o;
    release dut.rsp_ph_cnt_o;
    #1;
    checks++; if (addr_cnt !== 32'hFFFF_FFFE) begin errs++; $display("FAIL wrap_preload: got %0h exp fffffffe", addr_cnt); end
    drv(1, 1, 32'h0, 0); step();
    drv(1, 1, 32'h4, 1); step();
    drv(1, 1, 32'h8, 1); step();
    checks++; if (addr_cnt !== 32'd1) begin errs++; $display("FAIL wrap_addr_cnt: got %0h exp 1", addr_cnt); end
    drv(0, 0, 32'h0, 1); step(); drv(0, 0, 32'h0, 0);
    checks++; if (rsp_cnt !== 32'd1) begin errs++; $display("FAIL wrap_rsp_cnt: got %0h exp 1", rsp_cnt); end
    checks++; if (outst !== 2'd0)    begin errs++; $display("FAIL wrap_outst: got %0d exp 0", outst); end
    checks++; if (perr !== 1'b0)     begin errs++; $display("FAIL wrap_err: got %0b exp 0", perr); end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    do_reset();
    drv(1, 1, 32'h300, 0); step(); drv(0, 0, 32'h0, 0);   // grant at g, now g+1
    checks++; if (stall !== 8'd0) begin errs++; $display("FAIL stall_g1: got %0d exp 0", stall); end
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = STALL_EN ? 8'(k) : 8'd0;
      checks++; if (stall !== exp) begin errs++; $display("FAIL stall_cnt_%0d: got %0d exp %0d", k, stall, exp); end
    end
    drv(0, 0, 32'h0, 1); step(); drv(0, 0, 32'h0, 0);    // rvalid at g+10
    exp = STALL_EN ? 8'd9 : 8'd0;
    checks++; if (stall !== 8'd0) begin errs++; $display("FAIL stall_clear: got %0d exp 0", stall); end
    checks++; if (mstall !== exp) begin errs++; $display("FAIL stall_max: got %0d exp %0d", mstall, exp); end
    step();
    checks++; if (mstall !== exp) begin errs++; $display("FAIL stall_max_hold: got %0d exp %0d", mstall, exp); end
    checks++; if (perr !== 1'b0 || outst !== 2'd0) begin errs++; $display("FAIL stall_clean: err %0b outst %0d exp 0/0", perr, outst); end
  endtask

  initial begin
    drv(0, 0, 32'h0, 0);
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_wait_gnt(1'b0);
    test_wait_gnt(1'b1);
    test_stray_rsp();
    test_back_to_back();
    test_wrap();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
